// File: rtl/reg_chain_pipeline_pkg.sv
// Shared constants and helpers for the back-pressurable register chain.
// The per-stage data/valid record is declared where DATA_WIDTH is known.
package reg_chain_pipeline_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_DEPTH       = 2;
  localparam int DEFAULT_RESET_VALUE = 0;

  // Occupancy must be able to represent every value from 0 to depth.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_chain_stage.sv
// One data/valid register of the chain.
// A stage loads from its predecessor when it is empty or its successor can move.
module reg_chain_stage
  import reg_chain_pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] prev_data,
  input  logic                  prev_vld,
  input  logic                  next_rd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  vld,
  output logic                  rd
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  vld;
  } stage_t;

  stage_t stage_q;

  // An empty stage always accepts, which is what collapses bubbles.
  assign rd = ~stage_q.vld | next_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '{data: RESET_VALUE, vld: 1'b0};
    end else if (flush) begin
      stage_q <= '{data: RESET_VALUE, vld: 1'b0};
    end else if (rd) begin
      stage_q.vld <= prev_vld;
      // Data is kept when a bubble moves in so out_data never shows garbage.
      if (prev_vld) begin
        stage_q.data <= prev_data;
      end
    end
  end

  assign data = stage_q.data;
  assign vld  = stage_q.vld;

endmodule

// File: rtl/reg_chain_pipeline.sv
// DEPTH-stage retiming chain with valid/ready on both ends, bubble collapse,
// synchronous flush and a registered occupancy count.
module reg_chain_pipeline
  import reg_chain_pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int                    DEPTH       = DEFAULT_DEPTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(DEFAULT_RESET_VALUE),
  localparam int                   OCC_W       = occ_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_vld,
  input  logic                  out_rd,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0]      stage_vld;
  logic [DEPTH:0]        rd_chain;
  logic                  accept;
  logic                  consume;
  logic [OCC_W-1:0]      occ_q;

  // rd_chain[k] is stage k's readiness; the extra top bit is the sink.
  assign rd_chain[DEPTH] = out_rd;

  assign in_rd   = rd_chain[0] & ~flush & rst_n;
  assign accept  = in_vld & in_rd;
  assign consume = stage_vld[DEPTH-1] & out_rd;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [DATA_WIDTH-1:0] prev_data;
    logic                  prev_vld;

    if (k == 0) begin : g_head
      assign prev_data = in_data;
      assign prev_vld  = accept;
    end else begin : g_body
      assign prev_data = stage_data[k-1];
      assign prev_vld  = stage_vld[k-1];
    end

    reg_chain_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .prev_data (prev_data),
      .prev_vld  (prev_vld),
      .next_rd   (rd_chain[k+1]),
      .data      (stage_data[k]),
      .vld       (stage_vld[k]),
      .rd        (rd_chain[k])
    );
  end

  // Tracked incrementally so the count is a clean register, not a popcount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(accept) - OCC_W'(consume);
    end
  end

  assign occupancy = occ_q;
  assign out_data  = stage_data[DEPTH-1];
  assign out_vld   = stage_vld[DEPTH-1];

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    int'(occ_q) <= DEPTH);

  a_occ_matches_vld: assert property (@(posedge clk) disable iff (!rst_n)
    int'(occ_q) == $countones(stage_vld));

endmodule

// File: tb/tb_reg_chain_pipeline.sv
// Bench for reg_chain_pipeline: directed scenarios plus randomized traffic
// against a queue-of-words model, on a DEPTH=2/8-bit and a DEPTH=4/16-bit instance.
module tb_reg_chain_pipeline;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_vld;
  logic        out_rd;
  logic [15:0] in_data;

  logic        in_rd2, out_vld2;
  logic [7:0]  out_data2;
  logic [1:0]  occ2;
  logic        in_rd4, out_vld4;
  logic [15:0] out_data4;
  logic [2:0]  occ4;

  logic        sel;
  logic        o_in_rd, o_vld;
  logic [15:0] o_data;
  logic [2:0]  o_occ;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: words in FIFO order, each with its stage position (DEPTH-1 = output).
  int          m_depth;
  int          q_pos [$];
  logic [15:0] q_dat [$];
  logic [15:0] m_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  reg_chain_pipeline #(.DATA_WIDTH(8), .DEPTH(2), .RESET_VALUE(8'h00)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data[7:0]), .in_vld(in_vld),
    .in_rd(in_rd2), .out_data(out_data2), .out_vld(out_vld2), .out_rd(out_rd),
    .occupancy(occ2)
  );

  reg_chain_pipeline #(.DATA_WIDTH(16), .DEPTH(4), .RESET_VALUE(16'h0000)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_vld(in_vld),
    .in_rd(in_rd4), .out_data(out_data4), .out_vld(out_vld4), .out_rd(out_rd),
    .occupancy(occ4)
  );

  always_comb begin
    o_in_rd = in_rd2;
    o_vld   = out_vld2;
    o_data  = {8'h00, out_data2};
    o_occ   = {1'b0, occ2};
    if (sel) begin
      o_in_rd = in_rd4;
      o_vld   = out_vld4;
      o_data  = out_data4;
      o_occ   = occ4;
    end
  end

  function automatic bit m_in_rd();
    return (rst_n === 1'b1) && (flush === 1'b0) &&
           ((q_pos.size() < m_depth) || (out_rd === 1'b1));
  endfunction

  function automatic bit m_out_vld();
    return (q_pos.size() > 0) && (q_pos[0] == m_depth - 1);
  endfunction

  task automatic drive(input bit v, input logic [15:0] d, input bit ord, input bit fl);
    in_vld  = v;
    in_data = d;
    out_rd  = ord;
    flush   = fl;
    #1;
  endtask

  // Advance the model across the coming edge, then move to the next negedge.
  task automatic tick();
    bit acc, cons;
    int np;
    acc  = (in_vld === 1'b1) && m_in_rd();
    cons = m_out_vld() && (out_rd === 1'b1);
    if (rst_n !== 1'b1 || flush === 1'b1) begin
      q_pos.delete();
      q_dat.delete();
      m_last = '0;
    end else begin
      if (cons) begin
        void'(q_pos.pop_front());
        void'(q_dat.pop_front());
      end
      for (int i = 0; i < q_pos.size(); i++) begin
        np = q_pos[i] + 1;
        if (np > m_depth - 1) np = m_depth - 1;
        if (i > 0 && np > q_pos[i-1] - 1) np = q_pos[i-1] - 1;
        if (np == m_depth - 1 && q_pos[i] != m_depth - 1) m_last = q_dat[i];
        q_pos[i] = np;
      end
      if (acc) begin
        q_pos.push_back(0);
        q_dat.push_back(sel ? in_data : {8'h00, in_data[7:0]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit s);
    sel     = s;
    m_depth = s ? 4 : 2;
    rst_n   = 1'b0;
    drive(0, 16'h0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sel     = 1'b0;
    m_depth = 2;
    rst_n   = 1'b0;
    drive(0, 16'h0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld cyc%0d got %b want 0", c, o_vld); end
      n_tests++; if (o_in_rd !== 1'b0) begin n_fail++; $display("FAIL reset_in_rd cyc%0d got %b want 0", c, o_in_rd); end
      n_tests++; if (o_occ !== 3'd0) begin n_fail++; $display("FAIL reset_occ cyc%0d got %0d want 0", c, o_occ); end
      n_tests++; if (o_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data cyc%0d got %h want 0", c, o_data); end
      tick();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(0, 16'h0, 0, 0);
      n_tests++; if (o_in_rd !== 1'b1) begin n_fail++; $display("FAIL idle_in_rd cyc%0d got %b want 1", c, o_in_rd); end
      n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL idle_out_vld cyc%0d got %b want 0", c, o_vld); end
      n_tests++; if (o_data !== 16'h0) begin n_fail++; $display("FAIL idle_out_data cyc%0d got %h want 0", c, o_data); end
      n_tests++; if (o_occ !== 3'd0) begin n_fail++; $display("FAIL idle_occ cyc%0d got %0d want 0", c, o_occ); end
      tick();
    end
  endtask

  task automatic test_streaming();
    bit          vin [6];
    logic [7:0]  din [6];
    bit          e_vld [6];
    logic [7:0]  e_dat [6];
    int          e_occ [6];
    vin   = '{1, 1, 1, 0, 0, 0};
    din   = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    e_vld = '{0, 0, 1, 1, 1, 0};
    e_dat = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h33};
    e_occ = '{0, 1, 2, 2, 1, 0};
    for (int c = 0; c < 6; c++) begin
      drive(vin[c], {8'h00, din[c]}, 1, 0);
      n_tests++; if (o_in_rd !== 1'b1) begin n_fail++; $display("FAIL stream_in_rd cyc%0d got %b want 1", c, o_in_rd); end
      n_tests++; if (o_vld !== e_vld[c]) begin n_fail++; $display("FAIL stream_out_vld cyc%0d got %b want %b", c, o_vld, e_vld[c]); end
      n_tests++; if (o_data !== {8'h00, e_dat[c]}) begin n_fail++; $display("FAIL stream_out_data cyc%0d got %h want %h", c, o_data, e_dat[c]); end
      n_tests++; if (o_occ !== 3'(e_occ[c])) begin n_fail++; $display("FAIL stream_occ cyc%0d got %0d want %0d", c, o_occ, e_occ[c]); end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    drive(1, 16'h00A1, 0, 0);
    n_tests++; if (o_in_rd !== 1'b1) begin n_fail++; $display("FAIL bp_accept_a1 got %b want 1", o_in_rd); end
    tick();
    drive(0, 16'h0, 0, 0);
    n_tests++; if (o_occ !== 3'd1) begin n_fail++; $display("FAIL bp_occ_gap got %0d want 1", o_occ); end
    tick();
    drive(1, 16'h00A2, 0, 0);
    n_tests++; if (o_in_rd !== 1'b1) begin n_fail++; $display("FAIL bp_accept_a2 got %b want 1", o_in_rd); end
    n_tests++; if (o_vld !== 1'b1 || o_data !== 16'h00A1) begin n_fail++; $display("FAIL bp_head got vld=%b data=%h want vld=1 data=00a1", o_vld, o_data); end
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(0, 16'h0, 0, 0);
      n_tests++; if (o_in_rd !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_rd cyc%0d got %b want 0", c, o_in_rd); end
      n_tests++; if (o_occ !== 3'd2) begin n_fail++; $display("FAIL bp_full_occ cyc%0d got %0d want 2", c, o_occ); end
      n_tests++; if (o_data !== 16'h00A1) begin n_fail++; $display("FAIL bp_full_data cyc%0d got %h want 00a1", c, o_data); end
      tick();
    end
  endtask

  task automatic test_full_push_pop();
    drive(1, 16'h0055, 1, 0);
    n_tests++; if (o_in_rd !== 1'b1) begin n_fail++; $display("FAIL pp_in_rd got %b want 1", o_in_rd); end
    n_tests++; if (o_vld !== 1'b1 || o_data !== 16'h00A1) begin n_fail++; $display("FAIL pp_pop_a1 got vld=%b data=%h want vld=1 data=00a1", o_vld, o_data); end
    tick();
    drive(0, 16'h0, 1, 0);
    n_tests++; if (o_occ !== 3'd2) begin n_fail++; $display("FAIL pp_occ_kept got %0d want 2", o_occ); end
    n_tests++; if (o_vld !== 1'b1 || o_data !== 16'h00A2) begin n_fail++; $display("FAIL pp_pop_a2 got vld=%b data=%h want vld=1 data=00a2", o_vld, o_data); end
    tick();
    drive(0, 16'h0, 1, 0);
    n_tests++; if (o_vld !== 1'b1 || o_data !== 16'h0055) begin n_fail++; $display("FAIL pp_pop_55 got vld=%b data=%h want vld=1 data=0055", o_vld, o_data); end
    n_tests++; if (o_occ !== 3'd1) begin n_fail++; $display("FAIL pp_occ_drain got %0d want 1", o_occ); end
    tick();
    drive(0, 16'h0, 1, 0);
    n_tests++; if (o_vld !== 1'b0 || o_data !== 16'h0055 || o_occ !== 3'd0) begin n_fail++; $display("FAIL pp_empty got vld=%b data=%h occ=%0d want vld=0 data=0055 occ=0", o_vld, o_data, o_occ); end
    tick();
  endtask

  task automatic test_flush();
    drive(1, 16'h00B1, 0, 0);
    tick();
    drive(1, 16'h00B2, 0, 0);
    n_tests++; if (o_in_rd !== 1'b1) begin n_fail++; $display("FAIL fl_fill_in_rd got %b want 1", o_in_rd); end
    tick();
    drive(1, 16'h00CC, 1, 1);
    n_tests++; if (o_in_rd !== 1'b0) begin n_fail++; $display("FAIL fl_in_rd got %b want 0", o_in_rd); end
    n_tests++; if (o_vld !== 1'b1 || o_data !== 16'h00B1 || o_occ !== 3'd2) begin n_fail++; $display("FAIL fl_pre_state got vld=%b data=%h occ=%0d want vld=1 data=00b1 occ=2", o_vld, o_data, o_occ); end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 16'h0, 1, 0);
      n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL fl_out_vld cyc%0d got %b want 0", c, o_vld); end
      n_tests++; if (o_occ !== 3'd0) begin n_fail++; $display("FAIL fl_occ cyc%0d got %0d want 0", c, o_occ); end
      n_tests++; if (o_data !== 16'h0) begin n_fail++; $display("FAIL fl_out_data cyc%0d got %h want 0", c, o_data); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset(1);
    drive(1, 16'hC001, 0, 0); tick();
    drive(1, 16'hC002, 0, 0); tick();
    drive(1, 16'hC003, 0, 0); tick();
    drive(0, 16'h0, 0, 0); tick();
    drive(0, 16'h0, 0, 0);
    n_tests++; if (o_occ !== 3'd3 || o_vld !== 1'b1 || o_data !== 16'hC001) begin n_fail++; $display("FAIL ar_inflight got occ=%0d vld=%b data=%h want occ=3 vld=1 data=c001", o_occ, o_vld, o_data); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL ar_out_vld got %b want 0", o_vld); end
    n_tests++; if (o_in_rd !== 1'b0) begin n_fail++; $display("FAIL ar_in_rd got %b want 0", o_in_rd); end
    n_tests++; if (o_occ !== 3'd0) begin n_fail++; $display("FAIL ar_occ got %0d want 0", o_occ); end
    n_tests++; if (o_data !== 16'h0) begin n_fail++; $display("FAIL ar_out_data got %h want 0", o_data); end
    tick();
    rst_n = 1'b1;
    drive(1, 16'hD00D, 1, 0);
    n_tests++; if (o_in_rd !== 1'b1) begin n_fail++; $display("FAIL ar_release_in_rd got %b want 1", o_in_rd); end
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(0, 16'h0, 1, 0);
      n_tests++; if (o_vld !== (c == 4)) begin n_fail++; $display("FAIL ar_latency cyc%0d got %b want %b", c, o_vld, (c == 4)); end
      if (c == 4) begin
        n_tests++; if (o_data !== 16'hD00D) begin n_fail++; $display("FAIL ar_latency_data got %h want d00d", o_data); end
      end
      tick();
    end
  endtask

  task automatic test_random(input bit s, input int n);
    bit          v, ord, fl;
    logic [15:0] d;
    int          pct;
    do_reset(s);
    for (int i = 0; i < n; i++) begin
      pct = ((i / 48) % 2 == 1) ? 85 : 30;
      v   = ($urandom_range(0, 3) != 0);
      d   = 16'($urandom);
      ord = ($urandom_range(0, 99) < pct);
      fl  = ($urandom_range(0, 39) == 0);
      drive(v, d, ord, fl);
      n_tests++; if (o_in_rd !== m_in_rd()) begin n_fail++; $display("FAIL rnd%0d_in_rd cyc%0d got %b want %b", m_depth, i, o_in_rd, m_in_rd()); end
      n_tests++; if (o_vld !== m_out_vld()) begin n_fail++; $display("FAIL rnd%0d_out_vld cyc%0d got %b want %b", m_depth, i, o_vld, m_out_vld()); end
      n_tests++; if (o_data !== m_last) begin n_fail++; $display("FAIL rnd%0d_out_data cyc%0d got %h want %h", m_depth, i, o_data, m_last); end
      n_tests++; if (o_occ !== 3'(q_pos.size())) begin n_fail++; $display("FAIL rnd%0d_occ cyc%0d got %0d want %0d", m_depth, i, o_occ, q_pos.size()); end
      tick();
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    flush   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    out_rd  = 1'b0;
    sel     = 1'b0;
    m_depth = 2;
    m_last  = '0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    test_random(0, 400);
    test_random(1, 400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_chain_pipeline.md
Name: reg_chain_pipeline

Overview:
- Parametrised chain of DEPTH registered stages, each DATA_WIDTH wide, with a valid/ready handshake on both ends.
- Stalls are absorbed by collapsing bubbles: an empty stage always accepts data even when a later stage is blocked.
- Generalises the fixed two-register chain: configurable width and depth, occupancy reporting, synchronous flush.
- Used between hierarchy levels wherever a retimed, back-pressurable data path is needed.

Parameters:
- DATA_WIDTH, 8, bits per data word (>=1).
- DEPTH, 2, number of register stages (>=1).
- RESET_VALUE, 0, data content of every stage after reset and after flush.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset; assertion acts immediately, release is synchronous to clk.
- flush  in  1  synchronous clear of all stages.
- in_data  in  DATA_WIDTH  input word.
- in_vld  in  1  input word valid.
- in_rd  out  1  pipeline can accept a word this cycle.
- out_data  out  DATA_WIDTH  last-stage word.
- out_vld  out  1  last stage holds a valid word.
- out_rd  in  1  downstream accepts a word.
- occupancy  out  clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Stage state: data[k] and vld[k] for k = 0..DEPTH-1. Stage 0 faces the input; stage DEPTH-1 drives out_*.
- Reset (rst_n=0): all vld[k]=0 and all data[k]=RESET_VALUE, taking effect asynchronously. Outputs during reset: out_vld=0, out_data=RESET_VALUE, occupancy=0, in_rd=0.
- Stage readiness:
  - rd[DEPTH-1] = !vld[DEPTH-1] | out_rd.
  - rd[k] = !vld[k] | rd[k+1] for k < DEPTH-1.
  - This chain is combinational.
- in_rd = rd[0] & !flush & rst_n.
- Transfer rules at each rising edge when flush=0:
  - A stage with rd[k]=1 loads from its predecessor: data[k] <= data[k-1], vld[k] <= vld[k-1]. For stage 0 the predecessor is in_data and in_vld & in_rd.
  - A stage with rd[k]=0 holds its contents.
  - data[k] updates only when the incoming valid is 1; otherwise the old data is kept and only vld is cleared.
- Input handshake: a word is accepted iff in_vld & in_rd. Output handshake: a word is consumed iff out_vld & out_rd.
- Latency: a word accepted at edge t, with no stall, appears on out_data/out_vld after edge t+DEPTH-1, i.e. DEPTH cycles after it was presented.
- Throughput: 1 word/cycle when out_rd is held at 1.
- Capacity: DEPTH words. When all stages are valid and out_rd=0, in_rd=0 (full). Simultaneous input accept and output consume at full occupancy is allowed and occupancy is unchanged.
- Ordering: strict FIFO order; no word is duplicated or dropped.
- Flush:
  - flush=1 at an edge sets all vld to 0 and all data to RESET_VALUE.
  - in_rd=0 while flush=1, so nothing is accepted that cycle.
  - out_vld still reflects the pre-flush state during the flush cycle; a consume seen in that cycle is honoured by the sink.
  - Flush has priority over every transfer.
- occupancy: registered count of set vld bits, updated every edge.
  - Next value = occupancy + accept - consume, or 0 on flush or reset.
  - The count never exceeds DEPTH.
- out_data is undefined-free: when out_vld=0 it shows the last held data, or RESET_VALUE after reset or flush.
- Reset asserted mid-transfer: everything clears immediately; in-flight words are lost by design.

Decomposition:
- Shared package: the occupancy width function (clog2(DEPTH+1)), the default RESET_VALUE constant, and a stage record typedef (data, vld) parametrised by DATA_WIDTH.
- One natural sub-module, reg_chain_stage:
  - Holds one data/vld pair.
  - Inputs: prev data/vld, next rd, flush.
  - Outputs: data, vld, rd.
- reg_chain_pipeline instantiates DEPTH reg_chain_stage instances in a generate loop and adds the occupancy counter.

Test Plan (DATA_WIDTH=8, DEPTH=2 unless noted):
- Reset then idle: rst_n=0 for 3 cycles, then release → out_vld=0, out_data=0x00, occupancy=0; in_rd=1 from the first cycle after release.
- Streaming: out_rd=1; push 0x11, 0x22, 0x33 on consecutive cycles → out_vld goes high 2 cycles after 0x11 is accepted and shows 0x11, 0x22, 0x33 on consecutive cycles; occupancy peaks at 2.
- Back-pressure and bubble collapse: out_rd=0; push 0xA1, then idle 1 cycle, then push 0xA2 → both accepted; in_rd=0 afterwards with occupancy=2. Raise out_rd → 0xA1 then 0xA2 drain in order, and in_rd returns to 1 in the same cycle the first consume happens.
- Full with simultaneous push and pop: occupancy=2, in_vld=1 with 0x55, out_rd=1 → 0xA1 is consumed, 0x55 is accepted, occupancy stays 2.
- Flush: occupancy=2, assert flush for 1 cycle with in_vld=1 → in_rd=0 that cycle; next cycle out_vld=0, occupancy=0, out_data=RESET_VALUE, and the flush-cycle input is not captured.
- Async reset mid-stream (DEPTH=4, DATA_WIDTH=16): with 3 words in flight, drop rst_n between clock edges → out_vld, in_rd and occupancy go to 0 before the next edge; after release, new words flow normally with latency 4.
